// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op and state encodings,
// byte-lane select constants and RAM control levels.
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        LsuOpLb  = 3'b000,
        LsuOpLbu = 3'b001,
        LsuOpLh  = 3'b010,
        LsuOpLhu = 3'b011,
        LsuOpLw  = 3'b100,
        LsuOpSb  = 3'b101,
        LsuOpSh  = 3'b110,
        LsuOpSw  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } lsu_state_e;

    // Big-endian lanes: offset 0 is bits [31:24].
    localparam logic [3:0] SelByte0 = 4'b1000;
    localparam logic [3:0] SelHalf0 = 4'b1100;
    localparam logic [3:0] SelHalf2 = 4'b0011;
    localparam logic [3:0] SelWord  = 4'b1111;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    function automatic logic is_store(input lsu_op_e op);
        return op inside {LsuOpSb, LsuOpSh, LsuOpSw};
    endfunction

    function automatic logic is_half(input lsu_op_e op);
        return op inside {LsuOpLh, LsuOpLhu, LsuOpSh};
    endfunction

    function automatic logic is_word(input lsu_op_e op);
        return op inside {LsuOpLw, LsuOpSw};
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: store select/replication and load
// extraction with sign or zero extension.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[31:24];
        unique case (offset)
            2'd0: byte_lane = rdata[31:24];
            2'd1: byte_lane = rdata[23:16];
            2'd2: byte_lane = rdata[15:8];
            2'd3: byte_lane = rdata[7:0];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel        = '0;
        lane_wdata = '0;
        load_data  = '0;
        unique case (op)
            LsuOpLb: begin
                sel       = SelByte0 >> offset;
                load_data = {{24{byte_lane[7]}}, byte_lane};
            end
            LsuOpLbu: begin
                sel       = SelByte0 >> offset;
                load_data = {24'b0, byte_lane};
            end
            LsuOpLh: begin
                sel       = offset[1] ? SelHalf2 : SelHalf0;
                load_data = {{16{half_lane[15]}}, half_lane};
            end
            LsuOpLhu: begin
                sel       = offset[1] ? SelHalf2 : SelHalf0;
                load_data = {16'b0, half_lane};
            end
            LsuOpLw: begin
                sel       = SelWord;
                load_data = rdata;
            end
            LsuOpSb: begin
                sel        = SelByte0 >> offset;
                lane_wdata = {4{wdata[7:0]}};
            end
            LsuOpSh: begin
                sel        = offset[1] ? SelHalf2 : SelHalf0;
                lane_wdata = {2{wdata[15:0]}};
            end
            LsuOpSw: begin
                sel        = SelWord;
                lane_wdata = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request at a time, single-cycle RAM access,
// held response. Define LSU_ALIGN_EXC_EN to trap misaligned half/word accesses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              resp_wreg,
    output logic              resp_exc,
    output logic [ADDR_W-1:0] resp_badaddr,
    output logic              ram_ce,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q, req_op_e;
    logic [ADDR_W-1:0] addr_q, addr_fix, resp_badaddr_q;
    logic [31:0]       wdata_q, resp_data_q;
    logic [4:0]        rd_q;
    logic              resp_wreg_q, resp_exc_q;
    logic              accept, exc_hit, in_access;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata, load_data;

    assign req_op_e  = lsu_op_e'(req_op);
    assign accept    = (state_q == StIdle) && req_valid;
    assign in_access = (state_q == StAccess);

    // Forcing low bits is harmless with the exception enabled: misaligned
    // requests never reach ACCESS, and badaddr takes the raw address.
    always_comb begin
        addr_fix = req_addr;
        if (is_half(req_op_e)) begin
            addr_fix[0] = 1'b0;
        end else if (is_word(req_op_e)) begin
            addr_fix[1:0] = 2'b00;
        end
    end

`ifdef LSU_ALIGN_EXC_EN
    assign exc_hit = (is_half(req_op_e) && req_addr[0]) ||
                     (is_word(req_op_e) && (req_addr[1:0] != 2'b00));
`else
    assign exc_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = exc_hit ? StResp : StAccess;
            StAccess: state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            op_q           <= LsuOpLb;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            resp_data_q    <= '0;
            resp_wreg_q    <= 1'b0;
            resp_exc_q     <= 1'b0;
            resp_badaddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q           <= req_op_e;
                addr_q         <= addr_fix;
                wdata_q        <= req_wdata;
                rd_q           <= req_rd;
                resp_data_q    <= '0;
                resp_wreg_q    <= !is_store(req_op_e) && !exc_hit;
                resp_exc_q     <= exc_hit;
                resp_badaddr_q <= exc_hit ? req_addr : '0;
            end else if (in_access && !is_store(op_q)) begin
                resp_data_q <= load_data;
            end
        end
    end

    mem_lsu_align u_align (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (ram_rdata),
        .sel        (lane_sel),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = (state_q == StResp);
    assign resp_rd      = rd_q;
    assign resp_data    = resp_data_q;
    assign resp_wreg    = resp_wreg_q;
    assign resp_exc     = resp_exc_q;
    assign resp_badaddr = resp_badaddr_q;

    // RAM controls decode straight from the state register so reset kills them at once.
    assign ram_ce    = in_access ? ChipEnable : ChipDisable;
    assign ram_en    = (in_access && is_store(op_q)) ? WriteEnable : WriteDisable;
    assign ram_addr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign ram_sel   = in_access ? lane_sel : 4'b0000;
    assign ram_wdata = in_access ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus random traffic, checked against a
// byte-addressed big-endian memory model.
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, resp_valid, resp_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr, resp_badaddr, ram_addr;
    logic [31:0]       req_wdata, resp_data, ram_wdata, ram_rdata;
    logic [4:0]        req_rd, resp_rd;
    logic              resp_wreg, resp_exc, ram_ce, ram_en;
    logic [3:0]        ram_sel;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram [64];
    logic [7:0]  ref_mem [256];
    logic [31:0] last_data, last_bad;
    logic        last_exc;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .resp_wreg    (resp_wreg),
        .resp_exc     (resp_exc),
        .resp_badaddr (resp_badaddr),
        .ram_ce       (ram_ce),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_sel      (ram_sel),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // External data RAM: combinational read, byte-lane write on the clock edge.
    assign ram_rdata = ram[ram_addr[7:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_en) begin
            if (ram_sel[3]) ram[ram_addr[7:2]][31:24] <= ram_wdata[31:24];
            if (ram_sel[2]) ram[ram_addr[7:2]][23:16] <= ram_wdata[23:16];
            if (ram_sel[1]) ram[ram_addr[7:2]][15:8]  <= ram_wdata[15:8];
            if (ram_sel[0]) ram[ram_addr[7:2]][7:0]   <= ram_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
        int          sz = size_of(op);
        logic [31:0] v  = 32'h0;
        for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[8'(a + 32'(i))]);
        if (op == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic transact(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        int          sz, off;
        bit          is_st, exc;
        logic [31:0] a, exp_data, exp_wd;
        logic [3:0]  exp_sel;
        sz    = size_of(op);
        is_st = (op >= 3'd5);
        exc   = 1'b0;
`ifdef LSU_ALIGN_EXC_EN
        exc = (addr % sz) != 0;
        a   = addr;
`else
        a = addr - (addr % sz);
`endif
        off      = int'(a % 4);
        exp_data = (!is_st && !exc) ? model_load(op, a) : 32'h0;
        exp_sel  = 4'b0000;
        for (int i = 0; i < sz; i++) exp_sel[3 - off - i] = 1'b1;
        exp_wd = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (exc) begin
            check("exc_no_ce", 32'(ram_ce), 32'd0);
            check("exc_resp_valid", 32'(resp_valid), 32'd1);
        end else begin
            check("access_ce", 32'(ram_ce), 32'd1);
            check("access_en", 32'(ram_en), 32'(is_st));
            check("access_addr", ram_addr, {a[31:2], 2'b00});
            check("resp_valid_early", 32'(resp_valid), 32'd0);
            if (is_st) begin
                check("store_sel", 32'(ram_sel), 32'(exp_sel));
                check("store_wdata", ram_wdata, exp_wd);
            end
            @(posedge clk); #1;
            check("ce_one_cycle", 32'(ram_ce), 32'd0);
            check("resp_valid", 32'(resp_valid), 32'd1);
        end
        check("resp_data", resp_data, exp_data);
        check("resp_wreg", 32'(resp_wreg), 32'(!is_st && !exc));
        check("resp_exc", 32'(resp_exc), 32'(exc));
        check("resp_badaddr", resp_badaddr, exc ? addr : 32'h0);
        check("resp_rd", 32'(resp_rd), 32'(rd));
        last_data = resp_data; last_exc = resp_exc; last_bad = resp_badaddr;
        if (is_st && !exc)
            for (int i = 0; i < sz; i++)
                ref_mem[8'(a + 32'(i))] = 8'(wdata >> (8 * (sz - 1 - i)));
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_released", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 3'd0; req_addr = '0; req_wdata = '0; req_rd = '0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_ram_ce", 32'(ram_ce), 32'd0);
        check("rst_ram_bus", {ram_addr[27:0], ram_sel}, 32'h0);
        @(negedge clk); rst = 1'b1;

        transact(3'd7, 32'h10, 32'h1234_5678, 5'd1);
        transact(3'd4, 32'h10, 32'h0, 5'd2);
        check("lw_const", last_data, 32'h1234_5678);

        transact(3'd7, 32'h20, 32'h1234_8056, 5'd3);
        transact(3'd0, 32'h22, 32'h0, 5'd4);
        check("lb_const", last_data, 32'hFFFF_FF80);
        transact(3'd1, 32'h22, 32'h0, 5'd5);
        check("lbu_const", last_data, 32'h0000_0080);
        transact(3'd2, 32'h20, 32'h0, 5'd6);
        check("lh_const", last_data, 32'h0000_1234);

        transact(3'd6, 32'h12, 32'h0000_BEEF, 5'd7);
        transact(3'd4, 32'h10, 32'h0, 5'd8);
        check("sh_merge_const", last_data, 32'h1234_BEEF);

        transact(3'd4, 32'h13, 32'h0, 5'd9);
`ifdef LSU_ALIGN_EXC_EN
        check("misalign_exc", 32'(last_exc), 32'd1);
        check("misalign_bad", last_bad, 32'h13);
`else
        check("misalign_forced", last_data, 32'h1234_BEEF);
`endif

        // Response back-pressure with a competing request waiting.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h20; req_rd = 5'd10;
        @(posedge clk); #1;
        req_op = 3'd1; req_addr = 32'h22; req_rd = 5'd11;
        @(posedge clk); #1;
        held = resp_data;
        check("hold_first", held, 32'h1234_8056);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_ready_low", 32'(req_ready), 32'd0);
            check("hold_data", resp_data, held);
            check("hold_rd", 32'(resp_rd), 32'd10);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("no_bypass_ready", 32'(req_ready), 32'd1);
        check("no_bypass_ce", 32'(ram_ce), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pending_accept_ce", 32'(ram_ce), 32'd1);
        @(posedge clk); #1;
        check("pending_data", resp_data, model_load(3'd1, 32'h22));
        check("pending_rd", 32'(resp_rd), 32'd11);
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset in the middle of a store access must abort the write.
        transact(3'd7, 32'h30, 32'hCAFE_F00D, 5'd12);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h30; req_wdata = 32'h5555_5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_ce_before", 32'(ram_ce), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_ce_drop", 32'(ram_ce), 32'd0);
        check("abort_en_drop", 32'(ram_en), 32'd0);
        check("abort_idle", 32'(req_ready), 32'd1);
        check("abort_resp", 32'(resp_valid), 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b1;
        transact(3'd4, 32'h30, 32'h0, 5'd13);
        check("abort_old_value", last_data, 32'hCAFE_F00D);

        for (int n = 0; n < 40; n++)
            transact(3'($urandom_range(0, 7)), 32'($urandom_range(0, 250)),
                     $urandom, 5'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit sitting directly upstream of the data RAM in the MIPS32 MEM stage. It accepts one load or store request at a time from the pipeline over a valid/ready handshake and registers it. It drives the RAM's chip-enable, write-enable, word address, byte-select and write data for exactly one cycle, then aligns and extends the returned read data. It returns a held response to the pipeline (write-back register, data, exception flag).

## Interface
- ADDR_W, 32: byte-address width, matching the data address bus.
- clk  in  1  clock; RAM writes on the same rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_op  in  3  operation: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register (loads).
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  pipeline accepts response.
- resp_rd  out  5  echoed req_rd.
- resp_data  out  32  aligned/extended load data; 0 for stores.
- resp_wreg  out  1  1 for loads, 0 for stores and exceptions.
- resp_exc  out  1  misaligned-address exception.
- resp_badaddr  out  ADDR_W  faulting address (0 when resp_exc=0).
- ram_ce  out  1  RAM chip enable.
- ram_en  out  1  RAM write enable (1 = write).
- ram_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- ram_sel  out  4  byte lane select.
- ram_wdata  out  32  lane-replicated store data.
- ram_rdata  in  32  combinational RAM read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, register op/addr/wdata/rd and go to ACCESS. Under the exception macro, a misaligned request goes directly to RESP instead.
- ACCESS: ram_ce=1 for exactly this cycle. ram_en=1 for stores. ram_addr = {addr[ADDR_W-1:2],2'b00}.
  - Loads capture the aligned ram_rdata into resp_data at the end of the cycle.
  - Always advance to RESP.
- RESP: resp_valid=1 with stable outputs. On resp_ready, go to IDLE. There is no IDLE bypass, so the next request is accepted at the earliest the cycle after the handshake.
- Byte lanes are big-endian. Offset 0 is lane [31:24], sel 1000; offset 3 is sel 0001.
- Halfword select: offset 0 gives 1100, offset 2 gives 0011. Word select is 1111.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction: byte/halfword taken from the selected lane. LB/LH sign-extend; LBU/LHU zero-extend.
- Outside ACCESS, all ram_* outputs are 0.

## Timing
- Reset (asynchronous): state IDLE, req_ready=1, resp_valid=0, resp_* registers 0, all ram_* outputs 0.
- ram_* outputs are decoded from the state register, so ram_ce drops immediately when rst asserts.
- Reset during ACCESS aborts the access. No write occurs unless the clock edge completes before reset asserts.
- Latency: accept at edge N; ACCESS in cycle N+1; resp_valid in cycle N+2. Throughput is one request per 3 cycles.
- A misaligned request with the macro enabled gets resp_valid in cycle N+1 and never raises ram_ce.
- resp_ready held low: all resp_* outputs held stable and req_ready stays 0, indefinitely.
- req_valid deasserting while not ready is legal. No request is lost, because none was accepted.

## Configuration
- LSU_ALIGN_EXC_EN defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]≠0, sets resp_exc=1, resp_badaddr=addr, resp_wreg=0.
  - Neither the RAM nor resp_data is touched.
- LSU_ALIGN_EXC_EN undefined:
  - Low bits are forced (addr[0]=0 for halfword; addr[1:0]=0 for word).
  - resp_exc and resp_badaddr are tied 0.

## Structure
- Op encodings (LSU_OP_LB … LSU_OP_SW), state encodings, and the lane-select constants go in the shared defines.v.
- Chip-enable and write-enable levels reuse the existing defines.v constants.
- One natural sub-module, mem_lsu_align: combinational store lane/sel generation and load extraction/extension. The FSM and registers stay in mem_lsu.

## Test plan
- SW 0x12345678 @0x10, then LW @0x10:
  - The store shows sel=1111 for one cycle.
  - The load response is 0x12345678, with resp_valid two cycles after accept.
- Word 0x12348056 @0x20:
  - LB @0x22 gives 0xFFFFFF80.
  - LBU @0x22 gives 0x00000080.
  - LH @0x20 gives 0x00001234.
- SH 0xBEEF @0x12 over 0x12345678: ram_sel=0011, ram_wdata=0xBEEFBEEF; a following LW @0x10 gives 0x1234BEEF.
- LW @0x13:
  - Macro on: resp_exc=1, badaddr=0x13, ram_ce never high.
  - Macro off: data read from 0x10.
- Hold resp_ready=0 for 4 cycles: resp_* stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the handshake.
- Assert rst during ACCESS of SW @0x30: ram_ce falls immediately, the FSM returns to IDLE, and a later LW @0x30 returns the old value.
